// File: rtl/data_mem_responder.sv
// Word-addressed memory responder with a configurable access latency.
// One request at a time: accept, wait LATENCY cycles, respond over a valid/ready handshake.
module data_mem_responder #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4096,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_we_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [3:0]            req_wstrb_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                  rsp_err_o,
  output logic                  busy_o
);

  localparam int unsigned IdxW    = $clog2(DEPTH);
  localparam int unsigned CntW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int unsigned CntLoad = (LATENCY > 1) ? LATENCY - 2 : 0;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                state_q;
  logic [CntW-1:0]       cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic            accept;
  logic            addr_err;
  logic [IdxW-1:0] idx;

  assign accept   = req_valid_i && (state_q == StIdle);
  assign idx      = req_addr_i[IdxW+1:2];
  // DEPTH is a power of two, so any set bit above the index field means index >= DEPTH.
  assign addr_err = (req_addr_i[1:0] != 2'b00) || (req_addr_i[ADDR_WIDTH-1:IdxW+2] != '0);

  // Writes commit at the accept edge; reset blocks a coincident accept.
  always_ff @(posedge clk_i) begin
    if (!rst_i && accept && req_we_i && !addr_err) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (req_wstrb_i[b]) mem[idx][8*b +: 8] <= req_wdata_i[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (req_valid_i) begin
            err_q   <= addr_err;
            rdata_q <= (req_we_i || addr_err) ? '0 : mem[idx];
            if (LATENCY == 1) begin
              state_q <= StResp;
            end else begin
              state_q <= StWait;
              cnt_q   <= CntW'(CntLoad);
            end
          end
        end
        StWait: begin
          if (cnt_q == '0) state_q <= StResp;
          else             cnt_q   <= cnt_q - CntW'(1);
        end
        StResp: begin
          if (rsp_ready_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign req_ready_o = (state_q == StIdle);
  assign rsp_valid_o = (state_q == StResp);
  assign busy_o      = (state_q != StIdle);
  assign rsp_rdata_o = rdata_q;
  assign rsp_err_o   = err_q;

endmodule
